// File: rtl/instr_fetch_pkg.sv
// Shared constants for the instruction fetch stage.
package instr_fetch_pkg;

  localparam int unsigned IF_DATA_WIDTH        = 32;
  localparam int unsigned IF_INSTRUCTION_WIDTH = 32;
  localparam int unsigned IF_FIFO_DEPTH        = 2;

  localparam logic [IF_DATA_WIDTH-1:0]        IF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [IF_INSTRUCTION_WIDTH-1:0] IF_NOP_INSTR    = 32'h0000_0013;

  // Counter width able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous fetch buffer with flush; storage resets to a caller-supplied entry.
module instr_fetch_fifo #(
  parameter int unsigned      DEPTH       = 2,
  parameter int unsigned      WIDTH       = 65,
  parameter logic [WIDTH-1:0] RESET_ENTRY = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= RESET_ENTRY;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign full       = (count_q == CW'(DEPTH));
  assign count      = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: sequential PC generation, credit-limited memory requests,
// in-order response tagging and redirect handling with stale-response dropping.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = IF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(IF_RESET_VECTOR),
  parameter int unsigned           FIFO_DEPTH   = IF_FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            redirect_valid,
  input  logic [DATA_WIDTH-1:0]           redirect_pc,
  output logic                            imem_req_valid,
  input  logic                            imem_req_ready,
  output logic [DATA_WIDTH-1:0]           imem_req_addr,
  input  logic                            imem_rsp_valid,
  input  logic [IF_INSTRUCTION_WIDTH-1:0] imem_rsp_data,
  input  logic                            imem_rsp_err,
  output logic                            fetch_valid,
  input  logic                            fetch_ready,
  output logic [IF_INSTRUCTION_WIDTH-1:0] fetch_instruction,
  output logic [DATA_WIDTH-1:0]           fetch_pc,
  output logic                            fetch_fault
);

  localparam int unsigned IW = IF_INSTRUCTION_WIDTH;
  localparam int unsigned CW = cnt_width(FIFO_DEPTH);
  localparam int unsigned EW = 1 + DATA_WIDTH + IW;

  localparam logic [DATA_WIDTH-1:0] PC_STEP      = DATA_WIDTH'(4);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK   = ~DATA_WIDTH'(3);
  localparam logic [CW:0]           CREDIT_LIMIT = (CW+1)'(FIFO_DEPTH);
  localparam logic [EW-1:0]         RESET_ENTRY  = {1'b0, DATA_WIDTH'(0), IF_NOP_INSTR};

  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] rsp_pc_q;
  logic [DATA_WIDTH-1:0] redirect_tgt;
  logic [CW-1:0]         outstanding_q;
  logic [CW-1:0]         outstanding_d;
  logic [CW-1:0]         drop_cnt_q;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           credit_used;
  logic                  accept;
  logic                  dropping;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic [EW-1:0]         push_entry;
  logic [EW-1:0]         head_entry;

  assign redirect_tgt = redirect_pc & ALIGN_MASK;

  // Every request must have a guaranteed buffer slot when its response lands.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, fifo_count};
  assign imem_req_valid = reset && !redirect_valid && (credit_used < CREDIT_LIMIT);
  assign imem_req_addr  = pc_q;

  assign accept        = imem_req_valid && imem_req_ready;
  assign dropping      = imem_rsp_valid && (drop_cnt_q != '0);
  assign push          = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign pop           = fetch_valid && fetch_ready;
  assign outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
  assign push_entry    = {imem_rsp_err, rsp_pc_q, imem_rsp_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_VECTOR;
      rsp_pc_q      <= RESET_VECTOR;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      if (redirect_valid) begin
        pc_q       <= redirect_tgt;
        rsp_pc_q   <= redirect_tgt;
        drop_cnt_q <= outstanding_d;
      end else begin
        if (accept) begin
          pc_q <= pc_q + PC_STEP;
        end
        if (push) begin
          rsp_pc_q <= rsp_pc_q + PC_STEP;
        end
        if (dropping) begin
          drop_cnt_q <= drop_cnt_q - CW'(1);
        end
      end
    end
  end

  instr_fetch_fifo #(
    .DEPTH       (FIFO_DEPTH),
    .WIDTH       (EW),
    .RESET_ENTRY (RESET_ENTRY)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .head_data  (head_entry),
    .head_valid (fetch_valid),
    .full       (fifo_full),
    .count      (fifo_count)
  );

  assign {fetch_fault, fetch_pc, fetch_instruction} = head_entry;

  a_credit_bound: assert property (@(posedge clk) disable iff (!reset)
    credit_used <= CREDIT_LIMIT);

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
    push |-> !fifo_full);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a fixed-latency in-order memory model.
module tb_instr_fetch;

  localparam logic [31:0] DATA_OFS = 32'h1000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instruction;
  logic [31:0] fetch_pc;
  logic        fetch_fault;

  int pass_cnt;
  int total_cnt;
  int cyc;
  int mem_lat;
  logic        err_en;
  logic [31:0] err_addr;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] req_q[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_ins[$];
  logic        got_flt[$];
  int          got_cyc[$];

  instr_fetch dut (
    .clk               (clk),
    .reset             (reset),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .imem_req_valid    (imem_req_valid),
    .imem_req_ready    (imem_req_ready),
    .imem_req_addr     (imem_req_addr),
    .imem_rsp_valid    (imem_rsp_valid),
    .imem_rsp_data     (imem_rsp_data),
    .imem_rsp_err      (imem_rsp_err),
    .fetch_valid       (fetch_valid),
    .fetch_ready       (fetch_ready),
    .fetch_instruction (fetch_instruction),
    .fetch_pc          (fetch_pc),
    .fetch_fault       (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: accepts on valid&&ready, answers in order mem_lat cycles later.
  always @(negedge clk) begin
    #1;
    cyc++;
    if (!reset) begin
      pend_addr.delete();
      pend_due.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
    end else begin
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend_addr[0] + DATA_OFS;
        imem_rsp_err   = err_en && (pend_addr[0] == err_addr);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
      end
      if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + mem_lat);
      end
    end
  end

  // Log accepted requests and consumed fetch entries.
  always @(negedge clk) begin
    #3;
    if (reset && fetch_valid && fetch_ready) begin
      got_pc.push_back(fetch_pc);
      got_ins.push_back(fetch_instruction);
      got_flt.push_back(fetch_fault);
      got_cyc.push_back(cyc);
    end
    if (reset && imem_req_valid && imem_req_ready) begin
      req_q.push_back(imem_req_addr);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    req_q.delete();
    got_pc.delete();
    got_ins.delete();
    got_flt.delete();
    got_cyc.delete();
  endtask

  task automatic do_reset(input logic fr, input int lat);
    @(negedge clk);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    err_en         = 1'b0;
    imem_req_ready = 1'b1;
    fetch_ready    = fr;
    mem_lat        = lat;
    repeat (2) @(negedge clk);
    clear_logs();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", imem_req_valid);
    else pass_cnt++;
    total_cnt++;
    if (imem_req_addr !== 32'h0) $display("FAIL rst_req_addr: got %h want 00000000", imem_req_addr);
    else pass_cnt++;
    total_cnt++;
    if (fetch_valid !== 1'b0) $display("FAIL rst_fetch_valid: got %b want 0", fetch_valid);
    else pass_cnt++;
    total_cnt++;
    if (fetch_instruction !== NOP) $display("FAIL rst_instr: got %h want %h", fetch_instruction, NOP);
    else pass_cnt++;
    total_cnt++;
    if (fetch_pc !== 32'h0) $display("FAIL rst_pc: got %h want 00000000", fetch_pc);
    else pass_cnt++;
    total_cnt++;
    if (fetch_fault !== 1'b0) $display("FAIL rst_fault: got %b want 0", fetch_fault);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset(1'b1, 1);
    run_cycles(20);
    for (int i = 0; i < 6; i++) begin
      e = 32'(i * 4);
      total_cnt++;
      if (req_q.size() <= i) $display("FAIL stream_req[%0d]: missing, want %h", i, e);
      else if (req_q[i] !== e) $display("FAIL stream_req[%0d]: got %h want %h", i, req_q[i], e);
      else pass_cnt++;
      total_cnt++;
      if (got_pc.size() <= i) $display("FAIL stream_out[%0d]: missing, want pc %h", i, e);
      else if (got_pc[i] !== e || got_ins[i] !== e + DATA_OFS || got_flt[i] !== 1'b0)
        $display("FAIL stream_out[%0d]: got pc %h ins %h flt %b want pc %h ins %h flt 0",
                 i, got_pc[i], got_ins[i], got_flt[i], e, e + DATA_OFS);
      else pass_cnt++;
    end
    total_cnt++;
    if (got_cyc.size() < 2) $display("FAIL stream_back2back: fewer than 2 deliveries");
    else if (got_cyc[1] - got_cyc[0] !== 1)
      $display("FAIL stream_back2back: gap %0d cycles want 1", got_cyc[1] - got_cyc[0]);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int unstable;
    logic [31:0] e;
    unstable = 0;
    do_reset(1'b0, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fetch_valid && (fetch_pc !== 32'h0 || fetch_instruction !== DATA_OFS)) unstable++;
    end
    total_cnt++;
    if (unstable !== 0) $display("FAIL bp_head_stable: %0d unstable cycles want 0", unstable);
    else pass_cnt++;
    total_cnt++;
    if (req_q.size() !== 2) $display("FAIL bp_req_count: got %0d want 2", req_q.size());
    else pass_cnt++;
    total_cnt++;
    if (imem_req_valid !== 1'b0) $display("FAIL bp_credit_stop: got %b want 0", imem_req_valid);
    else pass_cnt++;
    total_cnt++;
    if (fetch_valid !== 1'b1) $display("FAIL bp_valid_held: got %b want 1", fetch_valid);
    else pass_cnt++;
    fetch_ready = 1'b1;
    run_cycles(20);
    for (int i = 0; i < 6; i++) begin
      e = 32'(i * 4);
      total_cnt++;
      if (got_pc.size() <= i) $display("FAIL bp_release[%0d]: missing, want %h", i, e);
      else if (got_pc[i] !== e || got_ins[i] !== e + DATA_OFS)
        $display("FAIL bp_release[%0d]: got pc %h ins %h want pc %h", i, got_pc[i], got_ins[i], e);
      else pass_cnt++;
    end
  endtask

  task automatic test_redirect_drop();
    logic [31:0] e;
    do_reset(1'b1, 3);
    run_cycles(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #1;
    total_cnt++;
    if (imem_req_valid !== 1'b0) $display("FAIL redir_mask: got %b want 0", imem_req_valid);
    else pass_cnt++;
    @(negedge clk);
    redirect_valid = 1'b0;
    total_cnt++;
    if (imem_req_addr !== 32'h100) $display("FAIL redir_pc: got %h want 00000100", imem_req_addr);
    else pass_cnt++;
    run_cycles(25);
    total_cnt++;
    if (req_q.size() < 3) $display("FAIL redir_req: only %0d requests", req_q.size());
    else if (req_q[0] !== 32'h0 || req_q[1] !== 32'h4 || req_q[2] !== 32'h100)
      $display("FAIL redir_req: got %h %h %h want 0 4 100", req_q[0], req_q[1], req_q[2]);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      e = 32'h100 + 32'(i * 4);
      total_cnt++;
      if (got_pc.size() <= i) $display("FAIL redir_out[%0d]: missing, want %h", i, e);
      else if (got_pc[i] !== e || got_ins[i] !== e + DATA_OFS)
        $display("FAIL redir_out[%0d]: got pc %h ins %h want pc %h", i, got_pc[i], got_ins[i], e);
      else pass_cnt++;
    end
  endtask

  task automatic test_misaligned();
    int idx;
    do_reset(1'b1, 1);
    run_cycles(5);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    @(negedge clk);
    redirect_valid = 1'b0;
    idx = got_pc.size();
    total_cnt++;
    if (imem_req_addr !== 32'h200) $display("FAIL align_req_addr: got %h want 00000200", imem_req_addr);
    else pass_cnt++;
    run_cycles(12);
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (got_pc.size() <= idx + i) $display("FAIL align_out[%0d]: missing", i);
      else if (got_pc[idx+i] !== 32'h200 + 32'(i * 4))
        $display("FAIL align_out[%0d]: got %h want %h", i, got_pc[idx+i], 32'h200 + 32'(i * 4));
      else pass_cnt++;
    end
  endtask

  task automatic test_fault();
    logic [31:0] e;
    logic        ef;
    do_reset(1'b1, 1);
    err_en   = 1'b1;
    err_addr = 32'h8;
    run_cycles(20);
    err_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      e  = 32'(i * 4);
      ef = (i == 2);
      total_cnt++;
      if (got_pc.size() <= i) $display("FAIL fault[%0d]: missing, want pc %h", i, e);
      else if (got_pc[i] !== e || got_flt[i] !== ef)
        $display("FAIL fault[%0d]: got pc %h flt %b want pc %h flt %b", i, got_pc[i], got_flt[i], e, ef);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap_async_reset();
    int idx;
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    exp_pc[3] = 32'h0000_0004;
    do_reset(1'b1, 1);
    run_cycles(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect_valid = 1'b0;
    idx = got_pc.size();
    run_cycles(14);
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (got_pc.size() <= idx + i) $display("FAIL wrap[%0d]: missing, want %h", i, exp_pc[i]);
      else if (got_pc[idx+i] !== exp_pc[i])
        $display("FAIL wrap[%0d]: got %h want %h", i, got_pc[idx+i], exp_pc[i]);
      else pass_cnt++;
    end
    fetch_ready = 1'b0;
    run_cycles(8);
    total_cnt++;
    if (fetch_valid !== 1'b1) $display("FAIL areset_pre_full: got valid %b want 1", fetch_valid);
    else pass_cnt++;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if (imem_req_valid !== 1'b0) $display("FAIL areset_req_valid: got %b want 0", imem_req_valid);
    else pass_cnt++;
    total_cnt++;
    if (imem_req_addr !== 32'h0) $display("FAIL areset_req_addr: got %h want 00000000", imem_req_addr);
    else pass_cnt++;
    total_cnt++;
    if (fetch_valid !== 1'b0) $display("FAIL areset_valid: got %b want 0", fetch_valid);
    else pass_cnt++;
    total_cnt++;
    if (fetch_instruction !== NOP) $display("FAIL areset_instr: got %h want %h", fetch_instruction, NOP);
    else pass_cnt++;
    total_cnt++;
    if (fetch_pc !== 32'h0) $display("FAIL areset_pc: got %h want 00000000", fetch_pc);
    else pass_cnt++;
    total_cnt++;
    if (fetch_fault !== 1'b0) $display("FAIL areset_fault: got %b want 0", fetch_fault);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    clear_logs();
    fetch_ready = 1'b1;
    reset       = 1'b1;
    run_cycles(10);
    total_cnt++;
    if (req_q.size() < 1) $display("FAIL restart_req: no request after reset");
    else if (req_q[0] !== 32'h0) $display("FAIL restart_req: got %h want 00000000", req_q[0]);
    else pass_cnt++;
    total_cnt++;
    if (got_pc.size() < 2) $display("FAIL restart_out: only %0d deliveries", got_pc.size());
    else if (got_pc[0] !== 32'h0 || got_pc[1] !== 32'h4)
      $display("FAIL restart_out: got %h %h want 00000000 00000004", got_pc[0], got_pc[1]);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt       = 0;
    total_cnt      = 0;
    cyc            = 0;
    mem_lat        = 1;
    err_en         = 1'b0;
    err_addr       = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    fetch_ready    = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_misaligned();
    test_fault();
    test_wrap_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
